// File: rtl/aes_job_sched_pkg.sv
// Shared types and constants for the AES job scheduler: FSM states, key-length
// codes and the key/block word layouts (word 0 in the least significant slot).
package aes_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  localparam logic [1:0] KL_128 = 2'd0;
  localparam logic [1:0] KL_192 = 2'd1;
  localparam logic [1:0] KL_256 = 2'd2;

  typedef logic [7:0][31:0] key_t;
  typedef logic [3:0][31:0] block_t;

  function automatic logic kl_legal(input logic [1:0] kl);
    return (kl == KL_128) || (kl == KL_192) || (kl == KL_256);
  endfunction

endpackage

// File: rtl/aes_job_sched_if.sv
// Requester/response bundle of the AES job scheduler; the scheduler is the
// slave, requesters and the response consumer together form the master.
interface aes_job_sched_if #(
  parameter int N_REQ = 2
) ();
  import aes_sched_pkg::*;

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  key_t [N_REQ-1:0]      req_key;
  logic [N_REQ-1:0][1:0] req_kl;
  logic [N_REQ-1:0]      req_enc_dec;
  block_t [N_REQ-1:0]    req_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  block_t                rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_key, req_kl, req_enc_dec, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_key, req_kl, req_enc_dec, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/aes_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping; the pointer register lives in the instantiating module.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic        found;
  logic [IW:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (en && !found && req[pos[IW-1:0]]) begin
        found            = 1'b1;
        gnt[pos[IW-1:0]] = 1'b1;
        idx              = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/aes_job_sched.sv
// Shares one AES core between N_REQ requesters: round-robin accept, key-cache
// to skip re-expansion, core launch via cu_clr/cu_ck, watchdog-guarded response.
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           CLR,
  aes_job_sched_if.slave host,
  output logic           cu_clr,
  output logic           cu_ck,
  output key_t           cu_key,
  output logic [1:0]     cu_kl,
  output logic           cu_enc_dec,
  output block_t         cu_state_i,
  input  block_t         cu_state_o,
  input  logic           cu_cf
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT);

  state_e           state, state_nxt;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx, rr_ptr;
  logic [WW-1:0]    wdog;
  logic             wdog_done, kl_ok, key_miss;
  key_t             sel_key, cache_key;
  logic [1:0]       sel_kl, cache_kl;
  logic             cache_vld;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (host.req_valid),
    .ptr (rr_ptr),
    .en  (state == IDLE),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign sel_key   = host.req_key[gnt_idx];
  assign sel_kl    = host.req_kl[gnt_idx];
  assign kl_ok     = kl_legal(sel_kl);
  // Direction is deliberately left out of the tag: the same schedule serves both.
  assign key_miss  = !cache_vld || (sel_key != cache_key) || (sel_kl != cache_kl);
  assign wdog_done = (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = kl_ok ? LOAD : RESP;
      LOAD:    state_nxt = RUN;
      RUN:     if (cu_cf || wdog_done) state_nxt = RESP;
      RESP:    if (host.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rr_ptr         <= '0;
      host.req_ready <= '0;
      host.rsp_valid <= 1'b0;
      host.rsp_id    <= '0;
      host.rsp_data  <= '0;
      host.rsp_err   <= 1'b0;
      cu_clr         <= 1'b1;
      cu_ck          <= 1'b1;
      cu_key         <= '0;
      cu_kl          <= '0;
      cu_enc_dec     <= 1'b0;
      cu_state_i     <= '0;
      cache_key      <= '0;
      cache_kl       <= '0;
      cache_vld      <= 1'b0;
      wdog           <= '0;
    end else begin
      host.req_ready <= gnt;
      case (state)
        // Accept: latch the job; an illegal key length answers without the core.
        IDLE: if (|gnt) begin
          rr_ptr      <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          cu_key      <= sel_key;
          cu_kl       <= sel_kl;
          cu_enc_dec  <= host.req_enc_dec[gnt_idx];
          cu_state_i  <= host.req_data[gnt_idx];
          host.rsp_id <= gnt_idx;
          if (!kl_ok) begin
            host.rsp_valid <= 1'b1;
            host.rsp_err   <= 1'b1;
            host.rsp_data  <= '0;
          end else begin
            cu_ck <= key_miss;
            if (key_miss) begin
              cache_key <= sel_key;
              cache_kl  <= sel_kl;
              cache_vld <= 1'b1;
            end
          end
        end
        LOAD: begin
          cu_clr <= 1'b0;
          cu_ck  <= 1'b0;
          wdog   <= '0;
        end
        // Completion beats a watchdog expiry landing in the same cycle.
        RUN: if (cu_cf) begin
          host.rsp_valid <= 1'b1;
          host.rsp_err   <= 1'b0;
          host.rsp_data  <= cu_state_o;
          cu_clr         <= 1'b1;
        end else if (wdog_done) begin
          host.rsp_valid <= 1'b1;
          host.rsp_err   <= 1'b1;
          host.rsp_data  <= '0;
          cu_clr         <= 1'b1;
          cache_vld      <= 1'b0;
        end else begin
          wdog <= wdog + WW'(1);
        end
        RESP: if (host.rsp_ready) host.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed bench for aes_job_sched with a fixed-latency core model that knows
// one FIPS-197 AES-128 vector.
module tb_aes_job_sched;
  import aes_sched_pkg::*;

  localparam int TIMEOUT = 32;
  localparam key_t KEY = {32'h0, 32'h0, 32'h0, 32'h0,
                          32'h0c0d0e0f, 32'h08090a0b, 32'h04050607, 32'h00010203};
  localparam block_t PT   = {32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
  localparam block_t CT   = {32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
  localparam block_t ZERO = '0;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       cu_clr, cu_ck, cu_enc_dec;
  logic       cu_cf = 1'b0;
  key_t       cu_key;
  logic [1:0] cu_kl;
  block_t     cu_state_i, cu_state_o;
  logic [3:0] core_cnt = '0;
  logic       core_hang = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  aes_job_sched_if #(.N_REQ(2)) bus ();

  aes_job_sched #(.N_REQ(2), .TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .host       (bus),
    .cu_clr     (cu_clr),
    .cu_ck      (cu_ck),
    .cu_key     (cu_key),
    .cu_kl      (cu_kl),
    .cu_enc_dec (cu_enc_dec),
    .cu_state_i (cu_state_i),
    .cu_state_o (cu_state_o),
    .cu_cf      (cu_cf)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Core model: cf rises after 11 clocks with cu_clr low, unless hung.
  always @(posedge CLK) begin
    if (cu_clr) begin
      core_cnt <= '0;
      cu_cf    <= 1'b0;
    end else if (!core_hang) begin
      core_cnt <= core_cnt + 4'd1;
      if (core_cnt == 4'd10) cu_cf <= 1'b1;
    end
  end

  always_comb begin
    if (cu_enc_dec) cu_state_o = (cu_state_i == PT) ? CT : ~cu_state_i;
    else            cu_state_o = (cu_state_i == CT) ? PT : ~cu_state_i;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_job(input string tag, input int r, input logic [1:0] kl, input logic enc,
                        input block_t d, input logic exp_ck, input block_t exp_d,
                        input logic exp_err, input int exp_lat, input int hold,
                        input logic [1:0] hold_vld);
    int         lat;
    logic       clr_high;
    logic [1:0] exp_rdy;
    exp_rdy              = 2'b01 << r;
    bus.req_key[r]       = KEY;
    bus.req_kl[r]        = kl;
    bus.req_enc_dec[r]   = enc;
    bus.req_data[r]      = d;
    bus.req_valid[r]     = 1'b1;
    lat = 0;
    do begin @(negedge CLK); lat++; end while (bus.req_ready == '0 && lat < 40);
    chk({tag, "_accept"}, bus.req_ready, exp_rdy);
    bus.req_valid = '0;
    if (kl != 2'd3) begin
      chk({tag, "_load_ck"}, cu_ck, exp_ck);
      chk({tag, "_load_key"}, cu_key, KEY);
      chk({tag, "_load_data"}, cu_state_i, d);
      chk({tag, "_load_dir"}, cu_enc_dec, enc);
    end
    chk({tag, "_load_clr"}, cu_clr, 1'b1);
    clr_high = 1'b1;
    lat = 1;
    while (!bus.rsp_valid && lat < 200) begin
      @(negedge CLK);
      lat++;
      if (lat == 2 && kl != 2'd3) chk({tag, "_run_clr"}, cu_clr, 1'b0);
      if (!cu_clr) clr_high = 1'b0;
    end
    if (kl == 2'd3) chk({tag, "_clr_held"}, clr_high, 1'b1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_rsp_id"}, bus.rsp_id, r);
    chk({tag, "_rsp_data"}, bus.rsp_data, exp_d);
    chk({tag, "_rsp_err"}, bus.rsp_err, exp_err);
    chk({tag, "_rsp_clr"}, cu_clr, 1'b1);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = hold_vld;
      @(negedge CLK);
      chk({tag, "_hold_valid"}, bus.rsp_valid, 1'b1);
      chk({tag, "_hold_data"}, bus.rsp_data, exp_d);
      chk({tag, "_hold_id"}, bus.rsp_id, r);
      chk({tag, "_hold_noacc"}, bus.req_ready, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    chk({tag, "_drain"}, bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int n;
    int last_acc;
    last_acc        = 0;
    CLR             = 1'b0;
    bus.req_valid   = '0;
    bus.req_key     = '0;
    bus.req_kl      = '0;
    bus.req_enc_dec = '0;
    bus.req_data    = '0;
    bus.rsp_ready   = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_clr", cu_clr, 1'b1);
    chk("reset_ck", cu_ck, 1'b1);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_req_ready", bus.req_ready, 2'b00);
    chk("reset_cu_key", cu_key, 256'h0);
    CLR = 1'b1;
    repeat (2) @(negedge CLK);

    do_job("single", 0, 2'd0, 1'b1, PT, 1'b1, CT, 1'b0, 14, 0, 2'b00);
    do_job("hit_dec", 1, 2'd0, 1'b0, CT, 1'b0, PT, 1'b0, 14, 0, 2'b00);

    bus.req_key     = {KEY, KEY};
    bus.req_kl      = '0;
    bus.req_enc_dec = 2'b11;
    bus.req_data    = {PT, PT};
    bus.req_valid   = 2'b11;
    bus.rsp_ready   = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n = 0;
      do begin @(negedge CLK); n++; end while (bus.req_ready == '0 && n < 40);
      chk("rr_grant", bus.req_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
      if (j > 0) chk("rr_period", cyc - last_acc, 15);
      last_acc = cyc;
      n = 0;
      do begin @(negedge CLK); n++; end while (!bus.rsp_valid && n < 40);
      chk("rr_id", bus.rsp_id, j % 2);
      chk("rr_data", bus.rsp_data, CT);
    end
    bus.req_valid = '0;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    @(negedge CLK);

    do_job("illegal_kl", 0, 2'd3, 1'b1, PT, 1'b0, ZERO, 1'b1, 1, 0, 2'b00);

    core_hang = 1'b1;
    do_job("timeout", 1, 2'd0, 1'b1, PT, 1'b0, ZERO, 1'b1, TIMEOUT + 2, 0, 2'b00);
    core_hang = 1'b0;

    bus.req_key[1]     = KEY;
    bus.req_kl[1]      = 2'd0;
    bus.req_enc_dec[1] = 1'b0;
    bus.req_data[1]    = CT;
    do_job("after_tmo", 0, 2'd0, 1'b1, PT, 1'b1, CT, 1'b0, 14, 20, 2'b10);
    do_job("post_bp", 1, 2'd0, 1'b0, CT, 1'b0, PT, 1'b0, 14, 0, 2'b00);

    bus.req_key[0]     = KEY;
    bus.req_kl[0]      = 2'd0;
    bus.req_enc_dec[0] = 1'b1;
    bus.req_data[0]    = PT;
    bus.req_valid[0]   = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (bus.req_ready == '0 && n < 40);
    chk("rst_accept", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    repeat (3) @(negedge CLK);
    chk("rst_run_clr", cu_clr, 1'b0);
    #2 CLR = 1'b0;
    #1;
    chk("arst_clr", cu_clr, 1'b1);
    chk("arst_ck", cu_ck, 1'b1);
    chk("arst_cu_key", cu_key, 256'h0);
    chk("arst_cu_kl", cu_kl, 2'd0);
    chk("arst_cu_dir", cu_enc_dec, 1'b0);
    chk("arst_cu_state", cu_state_i, ZERO);
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_rsp_data", bus.rsp_data, ZERO);
    chk("arst_rsp_id", bus.rsp_id, 1'b0);
    chk("arst_rsp_err", bus.rsp_err, 1'b0);
    chk("arst_req_ready", bus.req_ready, 2'b00);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);

    bus.req_key[1]     = KEY;
    bus.req_kl[1]      = 2'd0;
    bus.req_enc_dec[1] = 1'b1;
    bus.req_data[1]    = PT;
    bus.req_valid[1]   = 1'b1;
    do_job("post_rst", 0, 2'd0, 1'b1, PT, 1'b1, CT, 1'b0, 14, 0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
